// File: rtl/read_ctrl_pkg.sv
// Shared constants, state encoding and counter-width helper for the SPI read path.
package read_ctrl_pkg;

    localparam int DATA_WL   = 20;
    localparam int LINES     = 20;
    localparam int FRAME_LEN = 24;
    localparam int ADDR_WL   = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    function automatic int slot_wl(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SLOT_WL = slot_wl(FRAME_LEN);

endpackage

// File: rtl/read_piso_reg.sv
// Parallel-load, MSB-first shift register feeding MISO.
module read_piso_reg
    import read_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WL
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/read_controller.sv
// Line-buffer read controller: fetches line words and serializes them onto MISO.
// Optional macro READ_CONTROLLER_PARITY_EN puts even parity of the word in pad slot DATA_WL.
//   state | meaning
//   IDLE  | waiting for iSTART
//   FETCH | read strobe for line 0
//   LOAD  | line 0 word enters the shift register
//   SHIFT | one bit-slot per iEN; next line prefetched at slot DATA_WL
//   DONE  | one-cycle completion pulse
module read_controller
    import read_ctrl_pkg::*;
(
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCLR,
    input  logic               iEN,
    input  logic               iSTART,
    input  logic [DATA_WL-1:0] iRd_DATA,
    output logic               oRd_EN,
    output logic [ADDR_WL-1:0] oRd_ADDR,
    output logic               MISO,
    output logic               oBUSY,
    output logic               oRd_DONE
);

    localparam logic [SLOT_WL-1:0] SLOT_DATA_LAST = SLOT_WL'(DATA_WL - 1);
    localparam logic [SLOT_WL-1:0] SLOT_PAD0      = SLOT_WL'(DATA_WL);
    localparam logic [SLOT_WL-1:0] SLOT_LAST      = SLOT_WL'(FRAME_LEN - 1);
    localparam logic [ADDR_WL-1:0] LINE_LAST      = ADDR_WL'(LINES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SLOT_WL-1:0]   r_slot;
    logic [ADDR_WL-1:0]   r_line;
    logic [ADDR_WL-1:0]   r_addr;
    logic [DATA_WL-1:0]   r_hold;
    logic                 r_pf_pend;
    logic                 w_rd_en;
    logic [ADDR_WL-1:0]   w_rd_addr;
    logic [ADDR_WL-1:0]   w_line_nxt;
    logic                 w_load;
    logic [DATA_WL-1:0]   w_load_data;
    logic                 w_shift;
    logic                 w_sr_msb;
    logic                 w_pad_bit;
    logic                 w_miso;

    assign w_line_nxt = r_line + ADDR_WL'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_addr;
        w_load      = 1'b0;
        w_load_data = iRd_DATA;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (iSTART) w_state_nxt = FETCH;
            end
            FETCH: begin
                w_rd_en     = 1'b1;
                w_rd_addr   = '0;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (iEN) begin
                    w_shift = (r_slot < SLOT_DATA_LAST);
                    if (r_slot == SLOT_PAD0 && r_line < LINE_LAST) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_line_nxt;
                    end
                    if (r_slot == SLOT_LAST) begin
                        if (r_line < LINE_LAST) begin
                            w_load      = 1'b1;
                            w_load_data = r_hold;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Clear wins over everything, including a strobe that would fire this cycle.
        if (iCLR) begin
            w_state_nxt = IDLE;
            w_rd_en     = 1'b0;
            w_rd_addr   = r_addr;
            w_load      = 1'b0;
            w_shift     = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= IDLE;
            r_slot    <= '0;
            r_line    <= '0;
            r_addr    <= '0;
            r_hold    <= '0;
            r_pf_pend <= 1'b0;
        end else if (iCLR) begin
            r_state   <= IDLE;
            r_slot    <= '0;
            r_line    <= '0;
            r_addr    <= '0;
            r_hold    <= '0;
            r_pf_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_rd_addr;
            r_pf_pend <= w_rd_en;
            if (r_pf_pend) r_hold <= iRd_DATA;
            if (r_state == LOAD) begin
                r_slot <= '0;
                r_line <= '0;
            end else if (r_state == SHIFT && iEN) begin
                if (r_slot == SLOT_LAST) begin
                    r_slot <= '0;
                    if (r_line < LINE_LAST) r_line <= w_line_nxt;
                end else begin
                    r_slot <= r_slot + SLOT_WL'(1);
                end
            end
        end
    end

`ifdef READ_CONTROLLER_PARITY_EN
    logic r_par;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_par <= 1'b0;
        end else if (iCLR) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_load_data;
        end
    end

    assign w_pad_bit = r_par;
`else
    assign w_pad_bit = 1'b0;
`endif

    read_piso_reg #(
        .WIDTH (DATA_WL)
    ) u_piso (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_clr   (iCLR),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_data),
        .o_msb   (w_sr_msb)
    );

    always_comb begin
        w_miso = 1'b0;
        if (r_state == SHIFT) begin
            if (r_slot <= SLOT_DATA_LAST) w_miso = w_sr_msb;
            else if (r_slot == SLOT_PAD0) w_miso = w_pad_bit;
        end
    end

    assign MISO     = w_miso;
    assign oRd_EN   = w_rd_en;
    assign oRd_ADDR = w_rd_addr;
    assign oBUSY    = (r_state != IDLE);
    assign oRd_DONE = (r_state == DONE);

endmodule

// File: tb/tb_read_controller.sv
// Bench for read_controller: slot-count reference model plus directed literal checks.
module tb_read_controller;
    import read_ctrl_pkg::*;

`ifdef READ_CONTROLLER_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif
    localparam int TOTAL = LINES * FRAME_LEN;

    logic               iCLK, iRST, iCLR, iEN, iSTART;
    logic [DATA_WL-1:0] iRd_DATA;
    logic               oRd_EN, MISO, oBUSY, oRd_DONE;
    logic [ADDR_WL-1:0] oRd_ADDR;

    read_controller dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iCLR     (iCLR),
        .iEN      (iEN),
        .iSTART   (iSTART),
        .iRd_DATA (iRd_DATA),
        .oRd_EN   (oRd_EN),
        .oRd_ADDR (oRd_ADDR),
        .MISO     (MISO),
        .oBUSY    (oBUSY),
        .oRd_DONE (oRd_DONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic [DATA_WL-1:0] mem [0:LINES-1];
    initial iRd_DATA = '0;
    always @(posedge iCLK)
        if (oRd_EN && oRd_ADDR < ADDR_WL'(LINES)) iRd_DATA <= mem[oRd_ADDR];

    int checks = 0;
    int failures = 0;

    // model: slots consumed so far in the image, cycles since start
    int m_active, m_age, m_k, m_done, m_last;
    logic [63:0] cap;
    int ncap, n_done, n_slots;
    int q_addr[$];
    int q_k[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_age = 0; m_k = 0; m_done = 0; m_last = 0;
    endtask

    task automatic step(input logic en, input logic st, input logic cl);
        int line, slot;
        logic fetch, shifting, e_rd, e_miso;
        logic [ADDR_WL-1:0] e_addr;
        logic [DATA_WL-1:0] w;
        @(negedge iCLK);
        iEN = en; iSTART = st; iCLR = cl;
        #1;
        line = m_k / FRAME_LEN;
        slot = m_k % FRAME_LEN;
        if (line > LINES - 1) line = LINES - 1;
        fetch    = (m_active != 0) && (m_age == 0);
        shifting = (m_active != 0) && (m_age >= 2);
        w = mem[line];
        e_miso = 1'b0;
        if (shifting) begin
            if (slot < DATA_WL) e_miso = w[DATA_WL-1-slot];
            else if (slot == DATA_WL) e_miso = PAR_ON & (^w);
        end
        e_rd = !cl && (fetch || (shifting && en && slot == DATA_WL && line < LINES - 1));
        e_addr = e_rd ? (fetch ? ADDR_WL'(0) : ADDR_WL'(line + 1)) : ADDR_WL'(m_last);
        chk("miso", 64'(MISO), 64'(e_miso));
        chk("rd_en", 64'(oRd_EN), 64'(e_rd));
        chk("rd_addr", 64'(oRd_ADDR), 64'(e_addr));
        chk("busy", 64'(oBUSY), 64'(m_active != 0 || m_done != 0));
        chk("done", 64'(oRd_DONE), 64'(m_done != 0));
        if (oRd_EN) begin q_addr.push_back(int'(oRd_ADDR)); q_k.push_back(m_k); end
        if (oRd_DONE) n_done++;
        if (shifting && en && !cl) begin
            cap = {cap[62:0], MISO};
            ncap++;
            n_slots++;
        end
        if (cl) begin
            model_reset();
        end else begin
            if (e_rd) m_last = int'(e_addr);
            if (m_done != 0) begin
                m_done = 0;
            end else if (m_active == 0) begin
                if (st) begin m_active = 1; m_age = 0; m_k = 0; end
            end else if (m_age < 2) begin
                m_age++;
            end else if (en) begin
                m_k++;
                if (m_k == TOTAL) begin m_active = 0; m_done = 1; end
            end
        end
    endtask

    task automatic clear_obs();
        cap = '0; ncap = 0; n_done = 0; n_slots = 0;
        q_addr.delete(); q_k.delete();
    endtask

    task automatic run_slots(input int n, input int bound);
        for (int c = 0; c < bound && ncap < n; c++) step(1'b1, 1'b0, 1'b0);
        chk("slot_budget", 64'(ncap), 64'(n));
    endtask

    initial begin
        int bad;
        iRST = 1'b1; iCLR = 1'b0; iEN = 1'b0; iSTART = 1'b0;
        for (int i = 0; i < LINES; i++) mem[i] = '0;
        model_reset();
        clear_obs();
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        #1;
        chk("rst_busy", 64'(oBUSY), 64'd0);
        chk("rst_miso", 64'(MISO), 64'd0);
        chk("rst_rd_en", 64'(oRd_EN), 64'd0);
        chk("rst_addr", 64'(oRd_ADDR), 64'd0);
        chk("rst_done", 64'(oRd_DONE), 64'd0);

        // iEN while idle must not strobe memory
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // basic readout
        mem[0] = 20'hA5A5A; mem[1] = 20'h12345;
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        run_slots(24, 40);
        chk("basic_bits", cap[23:0], 64'hA5A5A0);
        chk("basic_nstrobe", 64'(q_addr.size()), 64'd2);
        if (q_addr.size() >= 2) begin
            chk("basic_addr0", 64'(q_addr[0]), 64'd0);
            chk("basic_addr1", 64'(q_addr[1]), 64'd1);
            chk("basic_pf_slot", 64'(q_k[1]), 64'd20);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // pad slot DATA_WL of an odd-parity word
        mem[0] = 20'h00001;
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        run_slots(24, 40);
        chk("parity_odd", 64'(cap[3]), 64'(PAR_ON));
        chk("parity_lsb", 64'(cap[4]), 64'd1);
        step(1'b0, 1'b0, 1'b1);

        // back-to-back slots across a line boundary
        mem[0] = 20'h00000; mem[1] = 20'hFFFFF;
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        run_slots(48, 80);
        chk("b2b_bits", cap[47:0], 64'h000000FFFFF0);
        step(1'b0, 1'b0, 1'b1);

        // full image, iEN every 4th cycle, iSTART pulses while busy
        for (int i = 0; i < LINES; i++) mem[i] = DATA_WL'(i + 1);
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3000 && n_done == 0; c++) step((c % 4) == 3, (c % 7) == 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("img_done_cnt", 64'(n_done), 64'd1);
        chk("img_slots", 64'(n_slots), 64'd480);
        chk("img_nstrobe", 64'(q_addr.size()), 64'd20);
        bad = 0;
        foreach (q_addr[i]) if (q_addr[i] != i) bad++;
        chk("img_addr_order", 64'(bad), 64'd0);
        chk("img_idle_after", 64'(oBUSY), 64'd0);

        // abort at line 7 slot 10
        for (int i = 0; i < LINES; i++) mem[i] = DATA_WL'($urandom);
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 2000 && !(m_age >= 2 && m_k == 7 * FRAME_LEN + 10); c++)
            step(1'($urandom % 2), 1'b0, 1'b0);
        chk("abort_pos", 64'(m_k), 64'(7 * FRAME_LEN + 10));
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_busy", 64'(oBUSY), 64'd0);
        chk("abort_miso", 64'(MISO), 64'd0);
        chk("abort_done", 64'(n_done), 64'd0);
        q_addr.delete();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("restart_nstrobe", 64'(q_addr.size()), 64'd1);
        if (q_addr.size() >= 1) chk("restart_addr", 64'(q_addr[0]), 64'd0);

        // async reset in the middle of SHIFT
        for (int c = 0; c < 60; c++) step(1'($urandom % 2), 1'b1, 1'b0);
        @(negedge iCLK);
        iEN = 1'b1; iSTART = 1'b0;
        #2 iRST = 1'b1;
        #1;
        chk("arst_busy", 64'(oBUSY), 64'd0);
        chk("arst_miso", 64'(MISO), 64'd0);
        chk("arst_rd_en", 64'(oRd_EN), 64'd0);
        chk("arst_addr", 64'(oRd_ADDR), 64'd0);
        chk("arst_done", 64'(oRd_DONE), 64'd0);
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            if (m_active == 0 && m_done == 0 && ($urandom % 8) == 0)
                for (int i = 0; i < LINES; i++) mem[i] = DATA_WL'($urandom);
            step(($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 700) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
